// File: rtl/wb_regfile.sv
// Architectural register file with two combinational read ports, one write port and a retired-write counter.
// Optional macro WB_REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wwreg,
  input  logic [ADDR_WIDTH-1:0] wrn,
  input  logic [DATA_WIDTH-1:0] wbData,
  input  logic [ADDR_WIDTH-1:0] rna,
  input  logic [ADDR_WIDTH-1:0] rnb,
  output logic [DATA_WIDTH-1:0] qa,
  output logic [DATA_WIDTH-1:0] qb,
  output logic [CNT_WIDTH-1:0]  wb_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wrEff;

  // Register 0 is hardwired zero, so writes to it neither commit nor count.
  assign wrEff = wwreg && (wrn != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEff) begin
      regs[wrn] <= wbData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count <= '0;
    end else if (wrEff) begin
      wb_count <= wb_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    qa = '0;
    qb = '0;
    if (rna != '0) begin
      qa = regs[rna];
    end
    if (rnb != '0) begin
      qb = regs[rnb];
    end
`ifdef WB_REGFILE_BYPASS_EN
    // wrEff already excludes index 0, so forwarding can never make r0 nonzero.
    if (wrEff && (rna == wrn)) begin
      qa = wbData;
    end
    if (wrEff && (rnb == wrn)) begin
      qb = wbData;
    end
`endif
  end

endmodule
